i2c_line_driver: RTL and testbench

// - Bit-level I2C master transmit engine: runs one bus command at a time (START, STOP, WRITE_BIT, READ_BIT).
// - Drives SCL/SDA through open-drain output enables. An enable of 1 pulls the line low.
// - Reads the bus back from the reset-high two-flop synchronizer outputs (scl_in_sync, sda_in_sync).
// - Supports clock stretching and arbitration-loss detection. Sits between the byte-level master FSM and the pads.

---
 rtl/i2c_pkg.sv | 11 +
 rtl/i2c_quarter_timer.sv | 18 +
 rtl/i2c_line_driver.sv | 110 +++++++++++
 tb/tb_i2c_line_driver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command and phase types for the I2C bit-level line driver.
package i2c_pkg;
  localparam int CMD_W = 2;
  typedef enum logic [CMD_W-1:0] {
    START     = 2'd0,
    STOP      = 2'd1,
    WRITE_BIT = 2'd2,
    READ_BIT  = 2'd3
  } i2c_cmd_t;
  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} drv_state_t;
endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: quarter-bit down-counter; holds while en is low, last flags the final cycle.
module i2c_quarter_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 last
);
  logic [DIV_WIDTH-1:0] cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign last = cnt == '0;
endmodule

// File: rtl/i2c_line_driver.sv
// i2c_line_driver: bit-level I2C master engine running START/STOP/WRITE_BIT/READ_BIT
// as four quarter phases, with clock stretching and arbitration-loss detection.
module i2c_line_driver
  import i2c_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 cmd_valid,
  input  logic [CMD_W-1:0]     cmd,
  input  logic                 cmd_bit,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 scl_in_sync,
  input  logic                 sda_in_sync,
  output logic                 cmd_ready,
  output logic                 done,
  output logic                 rd_bit,
  output logic                 arb_lost,
  output logic                 busy,
  output logic                 scl_oe,
  output logic                 sda_oe
);
  drv_state_t state, state_d;
  i2c_cmd_t cmd_r, c;
  logic bit_r, accept, en, last, tick;
  logic scl_d, sda_d, done_d, arb_d, rd_d;
  logic [DIV_WIDTH-1:0] qm1, qm1_d;

  assign c         = i2c_cmd_t'(cmd);
  assign cmd_ready = state == IDLE;
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign qm1_d     = clk_div == '0 ? '0 : clk_div - 1'b1;
  // B only advances once the bus actually shows SCL high (slave stretch)
  assign en        = state != IDLE && (state != PH_B || scl_in_sync);
  assign tick      = en & last;

  i2c_quarter_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (accept | tick),
    .en      (en),
    .load_val(accept ? qm1_d : qm1),
    .last    (last)
  );

  always_comb begin
    state_d = state;
    scl_d   = scl_oe;
    sda_d   = sda_oe;
    done_d  = 1'b0;
    arb_d   = 1'b0;
    rd_d    = rd_bit;
    if (accept) begin
      state_d = PH_A;
      scl_d   = c == START ? scl_oe : 1'b1;
      sda_d   = c == WRITE_BIT ? ~cmd_bit : c == STOP;
    end else if (tick) begin
      case (state)
        PH_A: begin
          state_d = PH_B;
          scl_d   = 1'b0;
        end
        PH_B: begin
          state_d = PH_C;
          sda_d   = cmd_r == START ? 1'b1 : cmd_r == STOP ? 1'b0 : sda_oe;
        end
        PH_C: begin
          arb_d   = cmd_r == WRITE_BIT && bit_r && !sda_in_sync;
          state_d = arb_d ? IDLE : PH_D;
          scl_d   = !arb_d && cmd_r != STOP;
          sda_d   = arb_d ? 1'b0 : sda_oe;
          rd_d    = cmd_r == READ_BIT ? sda_in_sync : rd_bit;
        end
        PH_D: begin
          arb_d   = cmd_r == STOP && !sda_in_sync;
          done_d  = !arb_d;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state    <= IDLE;
      cmd_r    <= START;
      bit_r    <= 1'b0;
      qm1      <= '0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      done     <= 1'b0;
      arb_lost <= 1'b0;
      rd_bit   <= 1'b0;
    end else begin
      state    <= state_d;
      scl_oe   <= scl_d;
      sda_oe   <= sda_d;
      done     <= done_d;
      arb_lost <= arb_d;
      rd_bit   <= rd_d;
      if (accept) begin
        cmd_r <= c;
        bit_r <= cmd_bit;
        qm1   <= qm1_d;
      end
    end
endmodule

// File: tb/tb_i2c_line_driver.sv
// tb_i2c_line_driver: scoreboard bench with an open-drain bus model, stretch and SDA-forcing stimulus.
module tb_i2c_line_driver;
  logic clk = 1'b0;
  logic n_rst, cmd_valid, cmd_bit, stretch, sda_low;
  logic [1:0] cmd;
  logic [15:0] clk_div;
  logic cmd_ready, done, rd_bit, arb_lost, busy, scl_oe, sda_oe;
  logic scl_in_sync, sda_in_sync;
  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    bit arb;
    bit rd_chk;
    bit rd;
    int at;
    bit scl;
    bit sda;
  } exp_t;
  exp_t sb[$];

  // wired-AND bus: a line is low if the master pulls it or the far side holds it
  assign scl_in_sync = ~scl_oe & ~stretch;
  assign sda_in_sync = ~sda_oe & ~sda_low;

  i2c_line_driver #(.DIV_WIDTH(16)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bit(cmd_bit),
    .clk_div(clk_div), .scl_in_sync(scl_in_sync), .sda_in_sync(sda_in_sync),
    .cmd_ready(cmd_ready), .done(done), .rd_bit(rd_bit), .arb_lost(arb_lost),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (n_rst && (done || arb_lost)) begin
      exp_t e;
      if (sb.size() == 0) chk("unexpected_event", {30'd0, done, arb_lost}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("event_kind", {30'd0, done, arb_lost}, e.arb ? 32'd1 : 32'd2);
        chk("event_cycle", cyc, e.at);
        chk("end_scl_oe", {31'd0, scl_oe}, {31'd0, e.scl});
        chk("end_sda_oe", {31'd0, sda_oe}, {31'd0, e.sda});
        if (e.rd_chk) chk("rd_bit", {31'd0, rd_bit}, {31'd0, e.rd});
      end
    end

  task automatic wait_idle();
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    chk("idle_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  // c: 0 START, 1 STOP, 2 WRITE_BIT, 3 READ_BIT; s: stretch cycles; fw: far side pulls SDA low
  task automatic run_cmd(input logic [1:0] c, input logic b, input logic [15:0] d, input int s, input bit fw);
    int q, lat, acc, at;
    bit arb;
    exp_t e;
    q   = d == 0 ? 1 : int'(d);
    lat = 4 * q + s;
    arb = (c == 2'd2 && b && fw) || (c == 2'd1 && fw);
    at  = arb && c == 2'd2 ? 3 * q + s : lat;
    @(negedge clk);
    wait_idle();
    cmd_valid = 1'b1; cmd = c; cmd_bit = b; clk_div = d;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0; cmd = 2'($urandom); cmd_bit = 1'($urandom); clk_div = 16'($urandom);
    e.arb = arb; e.at = acc + at; e.rd_chk = c == 2'd3; e.rd = !fw;
    e.scl = !arb && c != 2'd1;
    e.sda = !arb && (c == 2'd0 || (c == 2'd2 && !b));
    sb.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      stretch = k >= q && k < q + s;
      sda_low = fw && ((c >= 2'd2 && k >= 2 * q + s && k < 3 * q + s) ||
                       (c == 2'd1 && k >= 3 * q + s && k < lat));
      cmd_valid = k == 1 ? 1'($urandom) : 1'b0;
      if (k == 1 || k == 2) chk("busy_mid_cmd", {31'd0, busy}, 32'd1);
      if (c >= 2'd2 && k < (arb ? 3 * q + s : lat)) begin
        chk("scl_trace", {31'd0, scl_oe}, {31'd0, !(k >= q && k < 3 * q + s)});
        chk("sda_trace", {31'd0, sda_oe}, {31'd0, c == 2'd2 && !b});
      end
    end
    stretch = 1'b0; sda_low = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] rc;
    n_rst = 1'b0; cmd_valid = 1'b0; cmd = '0; cmd_bit = 1'b0; clk_div = '0;
    stretch = 1'b0; sda_low = 1'b0;
    #3;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oe", {30'd0, scl_oe, sda_oe}, 32'd0);
    chk("rst_pulses", {30'd0, done, arb_lost}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    run_cmd(2'd0, 1'b0, 16'd4, 0, 1'b0);
    run_cmd(2'd2, 1'b0, 16'd4, 0, 1'b0);
    run_cmd(2'd3, 1'b0, 16'd4, 0, 1'b0);
    run_cmd(2'd2, 1'b1, 16'd4, 10, 1'b0);
    run_cmd(2'd2, 1'b1, 16'd4, 0, 1'b1);
    @(negedge clk);
    chk("arb_ready", {31'd0, cmd_ready}, 32'd1);
    run_cmd(2'd3, 1'b0, 16'd2, 0, 1'b1);
    run_cmd(2'd1, 1'b0, 16'd0, 0, 1'b0);
    run_cmd(2'd1, 1'b0, 16'd1, 2, 1'b1);
    for (int i = 0; i < 40; i++) begin
      rc = 2'($urandom_range(0, 3));
      run_cmd(rc, 1'($urandom), 16'($urandom_range(0, 5)),
              $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 6)) : 0,
              rc != 2'd0 && $urandom_range(0, 1) == 1);
    end
    run_cmd(2'd3, 1'b0, 16'd1, 0, 1'b0);
    @(negedge clk);
    wait_idle();
    cmd_valid = 1'b1; cmd = 2'd2; cmd_bit = 1'b0; clk_div = 16'd4;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_oe", {30'd0, scl_oe, sda_oe}, 32'd3);
    chk("pre_rst_rd_bit", {31'd0, rd_bit}, 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_oe", {30'd0, scl_oe, sda_oe}, 32'd0);
    chk("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("async_rst_rd_bit", {31'd0, rd_bit}, 32'd0);
    chk("async_rst_pulses", {30'd0, done, arb_lost}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
